// File: rtl/dmem_req_ctrl_pkg.sv
// Shared definitions for the data-memory request controller: request layout,
// FSM state encoding and SRAM-like bus size codes.
package dmem_req_ctrl_pkg;

   localparam int REQ_W = 70;

   typedef struct packed {
      logic        en;
      logic        wen;
      logic [3:0]  sel;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_req_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ1  = 3'd1,
      WAIT1 = 3'd2,
      REQ2  = 3'd3,
      WAIT2 = 3'd4,
      DONE  = 3'd5
   } state_t;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/dmem_req_ctrl.sv
// Sequences the two load/store slots of an instruction pair onto a single
// SRAM-like data bus, one outstanding access at a time, slot 1 first.
module dmem_req_ctrl
   import dmem_req_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             accept,
   input  logic [REQ_W-1:0] req_i1,
   input  logic [REQ_W-1:0] req_i2,
   output logic             data_req,
   output logic             data_wr,
   output logic [1:0]       data_size,
   output logic [31:0]      data_addr,
   output logic [3:0]       data_wstrb,
   output logic [31:0]      data_wdata,
   input  logic             data_addr_ok,
   input  logic             data_data_ok,
   input  logic [31:0]      data_rdata,
   output logic [31:0]      rdata_i1,
   output logic [31:0]      rdata_i2,
   output logic             stallreq
);

   function automatic logic [1:0] sel_to_size(input logic [3:0] sel);
      case (sel)
         4'b1111:          sel_to_size = SIZE_WORD;
         4'b0011, 4'b1100: sel_to_size = SIZE_HALF;
         default:          sel_to_size = SIZE_BYTE;
      endcase
   endfunction

   state_t   state, state_n;
   logic     cancel, cancel_n;
   mem_req_t in1, in2;
   mem_req_t req1_q, req2_q, cur;
   logic     capture, latch1, latch2, start;

   assign in1   = req_i1;
   assign in2   = req_i2;
   assign start = (in1.en | in2.en) & ~flush;

   // A flush during an access only marks the pair cancelled; the bus handshake
   // in flight must still finish before we can drop back to IDLE.
   always_comb begin
      state_n  = state;
      cancel_n = cancel;
      capture  = 1'b0;
      latch1   = 1'b0;
      latch2   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               capture = 1'b1;
               state_n = in1.en ? REQ1 : REQ2;
            end
         end
         REQ1: begin
            cancel_n = cancel | flush;
            if (data_addr_ok) state_n = WAIT1;
         end
         WAIT1: begin
            cancel_n = cancel | flush;
            if (data_data_ok) begin
               if (cancel_n) begin
                  state_n = IDLE;
               end else begin
                  latch1  = ~req1_q.wen;
                  state_n = req2_q.en ? REQ2 : DONE;
               end
            end
         end
         REQ2: begin
            cancel_n = cancel | flush;
            if (data_addr_ok) state_n = WAIT2;
         end
         WAIT2: begin
            cancel_n = cancel | flush;
            if (data_data_ok) begin
               latch2  = ~cancel_n & ~req2_q.wen;
               state_n = cancel_n ? IDLE : DONE;
            end
         end
         DONE: begin
            if (flush || accept) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      if (state_n == IDLE) cancel_n = 1'b0;
   end

   // Bus fields are zero whenever no request is being presented.
   always_comb begin
      cur        = (state == REQ2) ? req2_q : req1_q;
      data_req   = (state == REQ1) || (state == REQ2);
      data_wr    = data_req ? cur.wen : 1'b0;
      data_size  = data_req ? sel_to_size(cur.sel) : 2'd0;
      data_addr  = data_req ? cur.addr : 32'd0;
      data_wstrb = data_req ? cur.sel : 4'd0;
      data_wdata = data_req ? cur.wdata : 32'd0;
      stallreq   = (state == IDLE) ? start : (state != DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cancel   <= 1'b0;
         req1_q   <= '0;
         req2_q   <= '0;
         rdata_i1 <= 32'd0;
         rdata_i2 <= 32'd0;
      end else begin
         state  <= state_n;
         cancel <= cancel_n;
         if (capture) begin
            req1_q <= in1;
            req2_q <= in2;
         end
         if (latch1) rdata_i1 <= data_rdata;
         if (latch2) rdata_i2 <= data_rdata;
      end
   end

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// Directed bench for dmem_req_ctrl: a small memory responder answers bus
// requests while a scoreboard checks each accepted request against expectations.
module tb_dmem_req_ctrl;

   typedef struct {
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        accept;
   logic [69:0] req_i1, req_i2;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic [3:0]  data_wstrb;
   logic        data_addr_ok, data_data_ok, resp_ok, spurious_ok;
   logic [31:0] rdata_i1, rdata_i2;
   logic        stallreq;

   int          total_cnt = 0;
   int          bad_cnt = 0;
   int          hs_count = 0;
   int          addr_delay = 0;
   int          data_delay = 1;
   exp_t        exp_q[$];
   logic [31:0] rd_q[$];

   assign data_data_ok = resp_ok | spurious_ok;

   always #5 clk = ~clk;

   dmem_req_ctrl dut (
      .clk(clk), .rst(rst), .flush(flush), .accept(accept),
      .req_i1(req_i1), .req_i2(req_i2),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .rdata_i1(rdata_i1), .rdata_i2(rdata_i2), .stallreq(stallreq)
   );

   function automatic logic [69:0] mk_req(input logic en, input logic wen, input logic [3:0] sel,
                                          input logic [31:0] addr, input logic [31:0] wdata);
      return {en, wen, sel, addr, wdata};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total_cnt++;
      if (actual !== expected) begin
         bad_cnt++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   task automatic timeoutFail(input string name);
      total_cnt++;
      bad_cnt++;
      $display("[TB] FAIL %s: timed out waiting", name);
   endtask

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   task automatic applyStimulus(input logic [69:0] r1, input logic [69:0] r2);
      req_i1 = r1;
      req_i2 = r2;
      accept = 1'b0;
      #1;
   endtask

   task automatic pushExp(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                          input logic [3:0] wstrb, input logic [31:0] wdata);
      exp_t e;
      e.wr = wr; e.size = size; e.addr = addr; e.wstrb = wstrb; e.wdata = wdata;
      exp_q.push_back(e);
   endtask

   task automatic waitIdle(input string name);
      int n = 0;
      while (stallreq && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) timeoutFail(name);
   endtask

   task automatic waitReq(input string name);
      int n = 0;
      while (!data_req && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) timeoutFail(name);
   endtask

   // Memory responder: addr_ok after addr_delay cycles, data_ok data_delay cycles later.
   initial begin
      int phase = 0;
      int cnt = 0;
      data_addr_ok = 1'b0;
      resp_ok      = 1'b0;
      data_rdata   = 32'd0;
      forever begin
         @(negedge clk);
         if (rst) begin
            phase = 0;
            data_addr_ok = 1'b0;
            resp_ok = 1'b0;
         end else begin
            case (phase)
               0: begin
                  resp_ok = 1'b0;
                  if (data_req) begin
                     cnt = addr_delay;
                     if (cnt == 0) begin data_addr_ok = 1'b1; phase = 2; end
                     else phase = 1;
                  end
               end
               1: begin
                  cnt--;
                  if (cnt == 0) begin data_addr_ok = 1'b1; phase = 2; end
               end
               2: begin
                  data_addr_ok = 1'b0;
                  cnt = data_delay;
                  if (cnt <= 1) begin
                     data_rdata = (rd_q.size() > 0) ? rd_q.pop_front() : 32'd0;
                     resp_ok = 1'b1;
                     phase = 0;
                  end else phase = 3;
               end
               default: begin
                  cnt--;
                  if (cnt <= 1) begin
                     data_rdata = (rd_q.size() > 0) ? rd_q.pop_front() : 32'd0;
                     resp_ok = 1'b1;
                     phase = 0;
                  end
               end
            endcase
         end
      end
   end

   // Scoreboard monitor: every accepted bus request must match the queue head.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (!rst && data_req && data_addr_ok) begin
            hs_count++;
            if (exp_q.size() == 0) begin
               total_cnt++;
               bad_cnt++;
               $display("[TB] FAIL unexpected_req: got addr %h expected no request", data_addr);
            end else begin
               e = exp_q.pop_front();
               checkOutput("req_wr", {31'd0, data_wr}, {31'd0, e.wr});
               checkOutput("req_size", {30'd0, data_size}, {30'd0, e.size});
               checkOutput("req_addr", data_addr, e.addr);
               checkOutput("req_wstrb", {28'd0, data_wstrb}, {28'd0, e.wstrb});
               checkOutput("req_wdata", data_wdata, e.wdata);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int base, n;
      rst = 1'b1; flush = 1'b0; accept = 1'b0; spurious_ok = 1'b0;
      req_i1 = '0; req_i2 = '0;
      tick();
      tick();
      checkOutput("rst_data_req", {31'd0, data_req}, 32'd0);
      checkOutput("rst_stallreq", {31'd0, stallreq}, 32'd0);
      checkOutput("rst_rdata_i1", rdata_i1, 32'd0);
      checkOutput("rst_rdata_i2", rdata_i2, 32'd0);
      rst = 1'b0;
      tick();

      // Slot-1 lw 0x1000
      $display("[TB] scenario: single load");
      addr_delay = 2; data_delay = 1;
      base = hs_count;
      pushExp(1'b0, 2'd2, 32'h0000_1000, 4'hF, 32'd0);
      rd_q.push_back(32'hDEAD_BEEF);
      applyStimulus(mk_req(1, 0, 4'hF, 32'h0000_1000, 32'd0), '0);
      n = 0;
      while (stallreq && n < 50) begin
         n++;
         tick();
      end
      checkOutput("s1_stall_cycles", n, 32'd5);
      checkOutput("s1_rdata_i1", rdata_i1, 32'hDEAD_BEEF);
      checkOutput("s1_handshakes", hs_count - base, 32'd1);
      req_i1 = '0; accept = 1'b1;
      tick();
      accept = 1'b0;
      tick();

      // Slot-1 sw half then slot-2 lb
      $display("[TB] scenario: store then load");
      addr_delay = 0; data_delay = 1;
      base = hs_count;
      pushExp(1'b1, 2'd1, 32'h0000_2002, 4'b0011, 32'h0000_BEEF);
      pushExp(1'b0, 2'd0, 32'h0000_3001, 4'b0100, 32'd0);
      rd_q.push_back(32'h1111_1111);
      rd_q.push_back(32'h00AB_0000);
      applyStimulus(mk_req(1, 1, 4'b0011, 32'h0000_2002, 32'h0000_BEEF),
                    mk_req(1, 0, 4'b0100, 32'h0000_3001, 32'd0));
      checkOutput("s2_stall_idle", {31'd0, stallreq}, 32'd1);
      waitIdle("s2_done");
      checkOutput("s2_handshakes", hs_count - base, 32'd2);
      checkOutput("s2_rdata_i1", rdata_i1, 32'hDEAD_BEEF);
      checkOutput("s2_rdata_i2", rdata_i2, 32'h00AB_0000);

      // accept held low in DONE with EX inputs still present
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("done_data_req", {31'd0, data_req}, 32'd0);
         checkOutput("done_stallreq", {31'd0, stallreq}, 32'd0);
         checkOutput("done_rdata_i2", rdata_i2, 32'h00AB_0000);
      end
      checkOutput("done_handshakes", hs_count - base, 32'd2);
      req_i1 = '0; req_i2 = '0; accept = 1'b1;
      tick();
      accept = 1'b0;
      tick();

      // flush in WAIT1 of a two-slot pair
      $display("[TB] scenario: flush in WAIT1");
      addr_delay = 0; data_delay = 3;
      base = hs_count;
      pushExp(1'b0, 2'd2, 32'h0000_4000, 4'hF, 32'd0);
      rd_q.push_back(32'h5555_5555);
      applyStimulus(mk_req(1, 0, 4'hF, 32'h0000_4000, 32'd0),
                    mk_req(1, 0, 4'hF, 32'h0000_4004, 32'd0));
      tick();
      waitReq("s3_req1");
      tick();
      flush = 1'b1; req_i1 = '0; req_i2 = '0;
      #1;
      checkOutput("s3_stall_wait", {31'd0, stallreq}, 32'd1);
      tick();
      flush = 1'b0;
      n = 0;
      while (!data_data_ok && n < 20) begin
         tick();
         n++;
      end
      if (n >= 20) timeoutFail("s3_data_ok");
      tick();
      checkOutput("s3_stall_after", {31'd0, stallreq}, 32'd0);
      checkOutput("s3_rdata_i1", rdata_i1, 32'hDEAD_BEEF);
      checkOutput("s3_rdata_i2", rdata_i2, 32'h00AB_0000);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("s3_no_req2", {31'd0, data_req}, 32'd0);
      end
      checkOutput("s3_handshakes", hs_count - base, 32'd1);

      // rst while the slot-2 request is pending
      $display("[TB] scenario: reset in REQ2");
      addr_delay = 3; data_delay = 1;
      base = hs_count;
      pushExp(1'b0, 2'd2, 32'h0000_5000, 4'hF, 32'd0);
      rd_q.push_back(32'h6666_6666);
      applyStimulus(mk_req(1, 0, 4'hF, 32'h0000_5000, 32'd0),
                    mk_req(1, 0, 4'hF, 32'h0000_5004, 32'd0));
      n = 0;
      while (hs_count == base && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) timeoutFail("s5_req1");
      tick();
      waitReq("s5_req2");
      checkOutput("s5_req2_addr", data_addr, 32'h0000_5004);
      checkOutput("s5_rdata_pre", rdata_i1, 32'h6666_6666);
      rst = 1'b1; req_i1 = '0; req_i2 = '0;
      #1;
      checkOutput("s5_data_req", {31'd0, data_req}, 32'd0);
      checkOutput("s5_data_addr", data_addr, 32'd0);
      checkOutput("s5_data_size", {30'd0, data_size}, 32'd0);
      checkOutput("s5_data_wstrb", {28'd0, data_wstrb}, 32'd0);
      checkOutput("s5_rdata_i1", rdata_i1, 32'd0);
      checkOutput("s5_rdata_i2", rdata_i2, 32'd0);
      checkOutput("s5_stallreq", {31'd0, stallreq}, 32'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      checkOutput("s5_idle_req", {31'd0, data_req}, 32'd0);

      // spurious data_ok in IDLE
      $display("[TB] scenario: spurious data_ok");
      data_rdata = 32'h1234_5678;
      spurious_ok = 1'b1;
      tick();
      tick();
      spurious_ok = 1'b0;
      tick();
      checkOutput("s6_rdata_i1", rdata_i1, 32'd0);
      checkOutput("s6_rdata_i2", rdata_i2, 32'd0);
      checkOutput("s6_stallreq", {31'd0, stallreq}, 32'd0);
      checkOutput("s6_data_req", {31'd0, data_req}, 32'd0);
      checkOutput("exp_queue_left", exp_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
